// File: rtl/abs_value_scheduler.sv
// abs_value_scheduler
//
// Round-robin front end for one shared absolute_value unit. Two complex-sample
// requesters (A and B) compete for the unit. The grant is combinational, so a
// sample is accepted on the same edge the unit samples its inputs. A small tag
// pipeline tracks the unit's 1-cycle latency, so each result leaves with its
// channel tag and an end-of-frame marker.
//
// Ports:
//   clock, resetN            system clock (rising edge); asynchronous active-low reset
//   enable                   low blocks new grants; in-flight results still drain
//   aValid/aReady/aDataRe/Im channel A valid/ready handshake and signed sample
//   bValid/bReady/bDataRe/Im channel B valid/ready handshake and signed sample
//   absEnable                enable to the shared unit (high on any grant)
//   absDataInRe/Im           granted channel's sample; zero when nothing is granted
//   absDataOut               registered result from the shared unit, 1 cycle later
//   outValid/outChannel      result valid and channel tag (0 = A, 1 = B)
//   outData/outLast          magnitude and last-sample-of-frame flag

module abs_value_scheduler #(
    parameter int unsigned DATA_WIDTH   = 18,
    parameter int unsigned FRAME_LENGTH = 1024
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  enable,
    input  logic                  aValid,
    output logic                  aReady,
    input  logic [DATA_WIDTH-1:0] aDataRe,
    input  logic [DATA_WIDTH-1:0] aDataIm,
    input  logic                  bValid,
    output logic                  bReady,
    input  logic [DATA_WIDTH-1:0] bDataRe,
    input  logic [DATA_WIDTH-1:0] bDataIm,
    output logic                  absEnable,
    output logic [DATA_WIDTH-1:0] absDataInRe,
    output logic [DATA_WIDTH-1:0] absDataInIm,
    input  logic [DATA_WIDTH-1:0] absDataOut,
    output logic                  outValid,
    output logic                  outChannel,
    output logic [DATA_WIDTH-1:0] outData,
    output logic                  outLast
);

    localparam int unsigned CntW = (FRAME_LENGTH > 1) ? $clog2(FRAME_LENGTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(FRAME_LENGTH - 1);

    logic            grant_a;
    logic            grant_b;
    logic            ptr_q;        // 0: A wins a tie, 1: B wins a tie
    logic [CntW-1:0] cnt_a_q;
    logic [CntW-1:0] cnt_b_q;
    logic            a_last;
    logic            b_last;
    logic            pend_valid_q;
    logic            pend_chan_q;
    logic            pend_last_q;
    logic            out_valid_q;
    logic            out_chan_q;
    logic            out_last_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    // Reset gates the grant so no handshake is seen while resetN is held.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (resetN && enable) begin
            if (aValid && (!bValid || !ptr_q)) begin
                grant_a = 1'b1;
            end else if (bValid) begin
                grant_b = 1'b1;
            end
        end
    end

    assign aReady    = grant_a;
    assign bReady    = grant_b;
    assign absEnable = grant_a | grant_b;

    always_comb begin
        absDataInRe = '0;
        absDataInIm = '0;
        if (grant_a) begin
            absDataInRe = aDataRe;
            absDataInIm = aDataIm;
        end else if (grant_b) begin
            absDataInRe = bDataRe;
            absDataInIm = bDataIm;
        end
    end

    assign a_last = (cnt_a_q == CntLast);
    assign b_last = (cnt_b_q == CntLast);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            ptr_q        <= 1'b0;
            cnt_a_q      <= '0;
            cnt_b_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_chan_q  <= 1'b0;
            pend_last_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_chan_q   <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
        end else begin
            if (grant_a) begin
                ptr_q   <= 1'b1;
                cnt_a_q <= a_last ? '0 : cnt_a_q + 1'b1;
            end else if (grant_b) begin
                ptr_q   <= 1'b0;
                cnt_b_q <= b_last ? '0 : cnt_b_q + 1'b1;
            end

            // Tag stage: mirrors the shared unit's internal register.
            pend_valid_q <= grant_a | grant_b;
            pend_chan_q  <= grant_b;
            pend_last_q  <= (grant_a & a_last) | (grant_b & b_last);

            // Output stage: capture the unit's result alongside its tag.
            out_valid_q <= pend_valid_q;
            out_chan_q  <= pend_chan_q;
            out_last_q  <= pend_last_q;
            if (pend_valid_q) begin
                out_data_q <= absDataOut;
            end
        end
    end

    assign outValid   = out_valid_q;
    assign outChannel = out_chan_q;
    assign outData    = out_data_q;
    assign outLast    = out_last_q;

endmodule

// File: tb/tb_abs_value_scheduler.sv
// tb_abs_value_scheduler
//
// Drives abs_value_scheduler (FRAME_LENGTH = 4) with directed steps. Includes a
// behavioural stand-in for the shared absolute_value unit: registered |re|+|im|
// with two's-complement wrap. A reference arbiter model predicts the grants and
// pushes the expected results into a scoreboard queue, tagged with the cycle in
// which each result should appear.

module tb_abs_value_scheduler;

    localparam int unsigned DW = 18;
    localparam int unsigned FL = 4;

    logic          clock;
    logic          resetN;
    logic          enable;
    logic          aValid;
    logic          aReady;
    logic [DW-1:0] aDataRe;
    logic [DW-1:0] aDataIm;
    logic          bValid;
    logic          bReady;
    logic [DW-1:0] bDataRe;
    logic [DW-1:0] bDataIm;
    logic          absEnable;
    logic [DW-1:0] absDataInRe;
    logic [DW-1:0] absDataInIm;
    logic [DW-1:0] absDataOut;
    logic          outValid;
    logic          outChannel;
    logic [DW-1:0] outData;
    logic          outLast;

    abs_value_scheduler #(
        .DATA_WIDTH  (DW),
        .FRAME_LENGTH(FL)
    ) dut (
        .clock      (clock),
        .resetN     (resetN),
        .enable     (enable),
        .aValid     (aValid),
        .aReady     (aReady),
        .aDataRe    (aDataRe),
        .aDataIm    (aDataIm),
        .bValid     (bValid),
        .bReady     (bReady),
        .bDataRe    (bDataRe),
        .bDataIm    (bDataIm),
        .absEnable  (absEnable),
        .absDataInRe(absDataInRe),
        .absDataInIm(absDataInIm),
        .absDataOut (absDataOut),
        .outValid   (outValid),
        .outChannel (outChannel),
        .outData    (outData),
        .outLast    (outLast)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DW-1:0] mag(input logic [DW-1:0] re, input logic [DW-1:0] im);
        logic [DW-1:0] ar;
        logic [DW-1:0] ai;
        ar = re[DW-1] ? DW'(-re) : re;
        ai = im[DW-1] ? DW'(-im) : im;
        return DW'(ar + ai);
    endfunction

    // Shared unit stand-in; deliberately not reset so a stale value lingers.
    initial absDataOut = '0;
    always @(posedge clock) begin
        if (absEnable) absDataOut <= mag(absDataInRe, absDataInIm);
    end

    typedef struct {
        int            due;
        logic          chan;
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   m_cnt_a  = 0;
    int   m_cnt_b  = 0;
    logic m_ptr    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic en, input logic av, input int are, input int aim,
                         input logic bv, input int bre, input int bim);
        enable  = en;
        aValid  = av;
        aDataRe = DW'(are);
        aDataIm = DW'(aim);
        bValid  = bv;
        bDataRe = DW'(bre);
        bDataIm = DW'(bim);
    endtask

    // One clock: check grants for the inputs already driven, predict the result,
    // advance one edge, then check the output stage against the scoreboard.
    task automatic tick();
        logic          ga;
        logic          gb;
        logic [DW-1:0] exp_re;
        logic [DW-1:0] exp_im;
        exp_t          e;
        #1;
        ga = resetN && enable && aValid && (!bValid || !m_ptr);
        gb = resetN && enable && bValid && !ga;
        chk("aReady", aReady, ga);
        chk("bReady", bReady, gb);
        chk("absEnable", absEnable, ga | gb);
        chk("readyExclusive", aReady & bReady, 1'b0);
        exp_re = ga ? aDataRe : gb ? bDataRe : '0;
        exp_im = ga ? aDataIm : gb ? bDataIm : '0;
        chk("absDataInRe", absDataInRe, exp_re);
        chk("absDataInIm", absDataInIm, exp_im);
        if (ga) begin
            sb.push_back('{cyc + 2, 1'b0, mag(aDataRe, aDataIm), m_cnt_a == FL - 1});
            m_cnt_a = (m_cnt_a == FL - 1) ? 0 : m_cnt_a + 1;
            m_ptr   = 1'b1;
        end else if (gb) begin
            sb.push_back('{cyc + 2, 1'b1, mag(bDataRe, bDataIm), m_cnt_b == FL - 1});
            m_cnt_b = (m_cnt_b == FL - 1) ? 0 : m_cnt_b + 1;
            m_ptr   = 1'b0;
        end
        @(posedge clock);
        cyc++;
        #1;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("outValid", outValid, 1'b1);
            chk("outChannel", outChannel, e.chan);
            chk("outData", outData, e.data);
            chk("outLast", outLast, e.last);
        end else begin
            chk("outValidIdle", outValid, 1'b0);
        end
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        #2;
        resetN = 1'b0;
        #1;
        chk("rstOutValid", outValid, 1'b0);
        chk("rstOutLast", outLast, 1'b0);
        chk("rstAReady", aReady, 1'b0);
        chk("rstBReady", bReady, 1'b0);
        chk("rstAbsEnable", absEnable, 1'b0);
        sb.delete();
        m_cnt_a = 0;
        m_cnt_b = 0;
        m_ptr   = 1'b0;
        #1;
        resetN = 1'b1;
    endtask

    int a_seq[4] = '{-5, 7, -1, 0};

    initial begin
        resetN = 1'b0;
        drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);

        // Reset held, then idle.
        repeat (3) tick();
        resetN = 1'b1;
        chk("resetOutData", outData, '0);
        chk("resetOutChannel", outChannel, 1'b0);
        chk("resetOutLast", outLast, 1'b0);
        repeat (2) tick();

        // Single channel stream (fills one frame on A).
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, a_seq[i], 0, 1'b0, 0, 0);
            tick();
        end
        drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
        repeat (3) tick();

        // Contention with complex data, then reset while results are in flight.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b1, 100 + i, -3 * i, 1'b1, -200 - i, 11 * i);
            tick();
        end
        pulse_reset();
        drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
        repeat (2) tick();

        // Frame wrap: 9 A transfers, last on the 4th and 8th.
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, (i == 4) ? -131072 : i * 3 - 7, i, 1'b0, 0, 0);
            tick();
        end
        drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
        repeat (3) tick();

        // Enable gap with both requesters valid.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 40 + i, 1, 1'b1, -50 - i, -2);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 9, 9, 1'b1, 8, 8);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 60 + i, -i, 1'b1, -70 - i, i);
            tick();
        end
        drive(1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
        repeat (3) tick();

        chk("scoreboardDrained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/abs_value_scheduler.md
Name: abs_value_scheduler

Overview:
- Round-robin scheduler that shares one absolute_value datapath instance between two complex sample requesters, channel A and channel B.
- Arbitrates per cycle, drives the datapath enable and input muxes, and tracks the datapath's 1-cycle latency so each result carries its channel tag.
- Counts samples per channel and flags the last sample of each frame.
- Sits between the matched-filter channel outputs and the downstream peak/threshold logic.

Parameters:
- DATA_WIDTH, 18, width of the Re/Im samples and of the magnitude result.
- FRAME_LENGTH, 1024, samples per frame per channel; must be ≥2. Counter width is $clog2(FRAME_LENGTH).

Ports:
- clock  in  1  system clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- enable  in  1  when low, no new grants are issued.
- aValid  in  1  channel A has a sample.
- aReady  out  1  channel A sample accepted this cycle.
- aDataRe  in  DATA_WIDTH  channel A real part, signed.
- aDataIm  in  DATA_WIDTH  channel A imaginary part, signed.
- bValid  in  1  channel B has a sample.
- bReady  out  1  channel B sample accepted this cycle.
- bDataRe  in  DATA_WIDTH  channel B real part, signed.
- bDataIm  in  DATA_WIDTH  channel B imaginary part, signed.
- absEnable  out  1  enable to the shared absolute_value unit.
- absDataInRe  out  DATA_WIDTH  real input to the shared unit.
- absDataInIm  out  DATA_WIDTH  imaginary input to the shared unit.
- absDataOut  in  DATA_WIDTH  registered result from the shared unit, valid 1 cycle after absEnable.
- outValid  out  1  result valid.
- outChannel  out  1  channel tag: 0 = A, 1 = B.
- outData  out  DATA_WIDTH  magnitude result.
- outLast  out  1  result is the last sample of that channel's frame.

Behaviour:
- **Reset** (resetN low, asynchronous): clears outValid, outChannel, outData, outLast, both frame counters, the pipeline tag register and the priority pointer (pointer = A). aReady, bReady and absEnable go low while reset is held.
- **Grant logic** (combinational, evaluated each cycle):
  - If enable=0, nothing is granted.
  - Only one valid requester: it is granted.
  - Both valid: the channel selected by the priority pointer is granted.
  - aReady = grantA and bReady = grantB; at most one is high. Ready depends on the requester's own valid; requesters must not wait for ready before raising valid.
  - A transfer occurs on valid && ready.
- **Priority pointer**: after any grant, the pointer moves to the non-granted channel. With no grant, it holds.
- **Datapath drive**:
  - absEnable = grantA | grantB.
  - absDataInRe/Im = the granted channel's data; all zeros when there is no grant.
  - The unit samples these on the same clock edge as the handshake.
- **Pipeline**:
  - At the handshake edge (T), register pendValid=1, pendChan, and pendLast = (that channel's counter == FRAME_LENGTH-1).
  - At edge T+1: outValid <= pendValid, outChannel <= pendChan, outLast <= pendLast, outData <= absDataOut when pendValid (else hold).
  - Result is visible 2 cycles after the handshake.
  - Throughput is 1 result per cycle. There is no output backpressure; the consumer must always accept.
- **Frame counters**:
  - There is one counter per channel. It increments only on that channel's transfer.
  - It wraps FRAME_LENGTH-1 → 0 on the transfer that is tagged pendLast.
  - The counters are independent; channel A's frame boundary does not affect channel B.
- **Enable deassertion** mid-frame: counters and pointer hold, and in-flight results still emerge on schedule. The frame resumes from the held count on re-enable.
- **Reset mid-operation**: the in-flight sample is discarded. outValid stays 0 until 2 cycles after the first post-reset handshake. The shared unit's stale output is ignored because pendValid is cleared.
- **Arithmetic**:
  - The scheduler passes data unmodified; magnitude is computed by the shared unit.
  - Input -2^(DATA_WIDTH-1) yields -2^(DATA_WIDTH-1) at outData (the shared unit's wrap). The scheduler does not saturate.

Test Plan:
1. **Reset and idle**: hold resetN=0 for 3 cycles, release with aValid=bValid=0 → all outputs and absEnable remain 0.
2. **Single channel stream**: aValid=1 for 4 cycles with aDataRe = -5, 7, -1, 0 → aReady=1 each cycle; outValid=1, outChannel=0, outData = 5, 7, 1, 0 starting 2 cycles after the first handshake.
3. **Contention**: aValid=bValid=1 continuously from reset → grants alternate A, B, A, B; outChannel toggles 0,1,0,1; no cycle has both ready signals high.
4. **Frame wrap** (FRAME_LENGTH=4): 9 A-only transfers → outLast=1 on the 4th and 8th results only; the 9th result has outLast=0.
5. **Enable gap**: drop enable for 3 cycles mid-stream with both valid → no ready during the gap; the 2 in-flight results still appear; arbitration resumes with the pointer unchanged.
6. **Async reset mid-stream**: pulse resetN low between edges while results are pending → outValid drops immediately; counters restart at 0; the next outLast falls after FRAME_LENGTH new transfers.
